// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register and the execute stage: decoded instruction in,
// registered EX/MEM fields and the upstream hold request out.
//
// Handshake: the decoder presents one instruction every cycle. When stall is high,
// upstream must hold the same instruction. The instruction is consumed at the first
// rising edge where stall is low. There is no separate valid; an all-zero control
// set is a bubble.
interface ex_stage_if #(parameter int WIDTH = 16);
  logic [3:0]       opcode;
  logic [3:0]       FN_offset;
  logic [3:0]       RA1;
  logic [3:0]       RA2;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic [WIDTH-1:0] SE_offset;
  logic             regWrite;
  logic             r0Write;
  logic             alusource;
  logic             memRead;
  logic             memWrite;
  logic             memSource;

  logic             stall;
  logic [WIDTH-1:0] ALUResult_o;
  logic [WIDTH-1:0] R0Result_o;
  logic [WIDTH-1:0] storeData_o;
  logic [3:0]       destReg_o;
  logic             regWrite_o;
  logic             r0Write_o;
  logic             memRead_o;
  logic             memWrite_o;
  logic             memSource_o;
  logic             overflow_o;

  logic             dbg_busy;
  logic [3:0]       dbg_count;

  modport master (
    output opcode, FN_offset, RA1, RA2, RD1, RD2, SE_offset,
    output regWrite, r0Write, alusource, memRead, memWrite, memSource,
    input  stall, ALUResult_o, R0Result_o, storeData_o, destReg_o,
    input  regWrite_o, r0Write_o, memRead_o, memWrite_o, memSource_o, overflow_o,
    input  dbg_busy, dbg_count
  );

  modport slave (
    input  opcode, FN_offset, RA1, RA2, RD1, RD2, SE_offset,
    input  regWrite, r0Write, alusource, memRead, memWrite, memSource,
    output stall, ALUResult_o, R0Result_o, storeData_o, destReg_o,
    output regWrite_o, r0Write_o, memRead_o, memWrite_o, memSource_o, overflow_o,
    output dbg_busy, dbg_count
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the 16-bit pipeline: single-cycle ALU/address ops, plus a
// 16-step iterative signed multiply (shift-add) and divide (restoring).
module ex_stage #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;
  localparam logic [3:0] OP_RTYPE = 4'b1111;
  localparam logic [3:0] FN_ADD   = 4'b0000;
  localparam logic [3:0] FN_SUB   = 4'b0001;
  localparam logic [3:0] FN_AND   = 4'b0010;
  localparam logic [3:0] FN_OR    = 4'b0011;
  localparam logic [3:0] FN_MUL   = 4'b0100;
  localparam logic [3:0] FN_DIV   = 4'b0101;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [0:0]       r_state;
  logic [3:0]       r_count;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ovf;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hold_data;
  logic [3:0]       r_hold_dest;
  logic             r_hold_rw, r_hold_r0w, r_hold_mr, r_hold_mw, r_hold_ms;

  logic [WIDTH-1:0] r_alu, r_r0, r_store;
  logic [3:0]       r_dest;
  logic             r_rw, r_r0w, r_mr, r_mw, r_ms, r_ovf_o;

  logic [WIDTH-1:0] w_a, w_b, w_sum, w_diff, w_abs_a, w_abs_b;
  logic             w_rtype, w_mul, w_div, w_divzero, w_start, w_last;
  logic [WIDTH-1:0] w_alu;
  logic             w_ovf, w_rw, w_r0w;
  logic [WIDTH:0]   w_mul_add, w_div_shift;
  logic [WIDTH-1:0] w_div_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_n, w_lo_n;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_res_lo, w_res_hi;
  logic             w_unused_ra2;

  assign w_unused_ra2 = ^bus.RA2;

  assign w_a       = bus.RD1;
  assign w_b       = bus.alusource ? bus.SE_offset : bus.RD2;
  assign w_sum     = w_a + w_b;
  assign w_diff    = w_a - w_b;
  assign w_abs_a   = w_a[WIDTH-1] ? -w_a : w_a;
  assign w_abs_b   = w_b[WIDTH-1] ? -w_b : w_b;
  assign w_rtype   = (bus.opcode == OP_RTYPE);
  assign w_mul     = w_rtype && (bus.FN_offset == FN_MUL);
  assign w_div     = w_rtype && (bus.FN_offset == FN_DIV);
  assign w_divzero = w_div && (w_b == '0);
  assign w_start   = (r_state == ST_IDLE) && (w_mul || w_div) && !w_divzero;
  assign w_last    = (r_state == ST_BUSY) && (r_count == 4'hF);

  assign bus.stall = !reset &&
                     (w_start || ((r_state == ST_BUSY) && (r_count != 4'hF)));

  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    w_rw  = bus.regWrite;
    w_r0w = bus.r0Write;
    if (!w_rtype) begin
      w_alu = bus.RD2 + bus.SE_offset;
    end else begin
      case (bus.FN_offset)
        FN_ADD: begin
          w_alu = w_sum;
          w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
          if (w_ovf) w_rw = 1'b0;
        end
        FN_SUB: begin
          w_alu = w_diff;
          w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
          if (w_ovf) w_rw = 1'b0;
        end
        FN_AND: w_alu = w_a & w_b;
        FN_OR:  w_alu = w_a | w_b;
        // Only the divide-by-zero case of MUL/DIV completes through this path.
        FN_MUL, FN_DIV: begin
          w_ovf = w_divzero;
          if (w_divzero) begin
            w_rw  = 1'b0;
            w_r0w = 1'b0;
          end
        end
        default: w_rw = 1'b0;
      endcase
    end
  end

  // One iteration step: r_lo holds the multiplier / dividend bits, r_hi the
  // partial product / partial remainder, r_opnd the multiplicand / divisor.
  assign w_mul_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;

  always_comb begin
    if (r_is_div) begin
      w_hi_n = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_hi_n = w_mul_add[WIDTH:1];
      w_lo_n = {w_mul_add[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_res_lo = r_is_div ? (r_neg_q ? -w_lo_n : w_lo_n) : w_prod_s[WIDTH-1:0];
  assign w_res_hi = r_is_div ? (r_neg_r ? -w_hi_n : w_hi_n) : w_prod_s[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;    r_count <= '0;
      r_is_div <= 1'b0;      r_neg_q <= 1'b0;   r_neg_r <= 1'b0;  r_ovf <= 1'b0;
      r_hi <= '0;            r_lo <= '0;        r_opnd <= '0;
      r_hold_data <= '0;     r_hold_dest <= '0;
      r_hold_rw <= 1'b0;     r_hold_r0w <= 1'b0;
      r_hold_mr <= 1'b0;     r_hold_mw <= 1'b0; r_hold_ms <= 1'b0;
      r_alu <= '0;  r_r0 <= '0;  r_store <= '0;  r_dest <= '0;
      r_rw <= 1'b0; r_r0w <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_ms <= 1'b0; r_ovf_o <= 1'b0;
    end else begin
      // Bubble unless a result is loaded below.
      r_alu <= '0;  r_r0 <= '0;  r_store <= '0;  r_dest <= '0;
      r_rw <= 1'b0; r_r0w <= 1'b0; r_mr <= 1'b0; r_mw <= 1'b0; r_ms <= 1'b0; r_ovf_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_BUSY;
            r_count     <= '0;
            r_is_div    <= w_div;
            r_neg_q     <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
            r_neg_r     <= w_a[WIDTH-1];
            r_ovf       <= w_div && (w_a == MIN_NEG) && (w_b == ALL_ONES);
            r_hi        <= '0;
            r_lo        <= w_abs_a;
            r_opnd      <= w_abs_b;
            r_hold_data <= bus.RD1;
            r_hold_dest <= bus.RA1;
            r_hold_rw   <= bus.regWrite;
            r_hold_r0w  <= bus.r0Write;
            r_hold_mr   <= bus.memRead;
            r_hold_mw   <= bus.memWrite;
            r_hold_ms   <= bus.memSource;
          end else begin
            r_alu   <= w_alu;
            r_store <= bus.RD1;
            r_dest  <= bus.RA1;
            r_rw    <= w_rw;
            r_r0w   <= w_r0w;
            r_mr    <= bus.memRead;
            r_mw    <= bus.memWrite;
            r_ms    <= bus.memSource;
            r_ovf_o <= w_ovf;
          end
        end
        ST_BUSY: begin
          r_hi    <= w_hi_n;
          r_lo    <= w_lo_n;
          r_count <= r_count + 4'd1;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_alu   <= w_res_lo;
            r_r0    <= w_res_hi;
            r_store <= r_hold_data;
            r_dest  <= r_hold_dest;
            r_rw    <= r_hold_rw && !r_ovf;
            r_r0w   <= r_hold_r0w && !r_ovf;
            r_mr    <= r_hold_mr;
            r_mw    <= r_hold_mw;
            r_ms    <= r_hold_ms;
            r_ovf_o <= r_ovf;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ALUResult_o = r_alu;
  assign bus.R0Result_o  = r_r0;
  assign bus.storeData_o = r_store;
  assign bus.destReg_o   = r_dest;
  assign bus.regWrite_o  = r_rw;
  assign bus.r0Write_o   = r_r0w;
  assign bus.memRead_o   = r_mr;
  assign bus.memWrite_o  = r_mw;
  assign bus.memSource_o = r_ms;
  assign bus.overflow_o  = r_ovf_o;
  assign bus.dbg_busy    = (r_state == ST_BUSY);
  assign bus.dbg_count   = r_count;
endmodule

// File: tb/tb_ex_stage.sv
// Directed plus randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  ex_stage_if #(.WIDTH(16)) bus();

  ex_stage #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ctl = {regWrite, r0Write, alusource, memRead, memWrite, memSource}
  task automatic set_in(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] ra1,
                        input logic [15:0] rd1, input logic [15:0] rd2, input logic [15:0] se,
                        input logic [5:0] ctl);
    bus.opcode = op;  bus.FN_offset = fn;  bus.RA1 = ra1;  bus.RA2 = ra1 ^ 4'h5;
    bus.RD1 = rd1;    bus.RD2 = rd2;       bus.SE_offset = se;
    {bus.regWrite, bus.r0Write, bus.alusource, bus.memRead, bus.memWrite, bus.memSource} = ctl;
  endtask

  function automatic logic [57:0] outv();
    return {bus.ALUResult_o, bus.R0Result_o, bus.storeData_o, bus.destReg_o,
            bus.regWrite_o, bus.r0Write_o, bus.memRead_o, bus.memWrite_o,
            bus.memSource_o, bus.overflow_o};
  endfunction

  function automatic logic [15:0] opnd_b();
    return bus.alusource ? bus.SE_offset : bus.RD2;
  endfunction

  // Expected output fields computed with signed integer arithmetic.
  function automatic logic [57:0] model();
    int a, b, r, q, m;
    logic [15:0] bu, alu, r0;
    logic wr, w0, ovf;
    bu = opnd_b();
    a = $signed(bus.RD1);
    b = $signed(bu);
    alu = '0; r0 = '0; ovf = 1'b0;
    wr = bus.regWrite; w0 = bus.r0Write;
    if (bus.opcode != 4'hF) begin
      alu = bus.RD2 + bus.SE_offset;
    end else begin
      case (bus.FN_offset)
        4'd0, 4'd1: begin
          r = (bus.FN_offset == 4'd0) ? a + b : a - b;
          alu = r[15:0];
          if (r > 32767 || r < -32768) begin ovf = 1'b1; wr = 1'b0; end
        end
        4'd2: alu = bus.RD1 & bu;
        4'd3: alu = bus.RD1 | bu;
        4'd4: begin r = a * b; alu = r[15:0]; r0 = r[31:16]; end
        4'd5: begin
          if (b == 0) begin
            ovf = 1'b1; wr = 1'b0; w0 = 1'b0;
          end else begin
            q = a / b; m = a % b;
            alu = q[15:0]; r0 = m[15:0];
            if (a == -32768 && b == -1) begin ovf = 1'b1; wr = 1'b0; w0 = 1'b0; end
          end
        end
        default: wr = 1'b0;
      endcase
    end
    return {alu, r0, bus.RD1, bus.RA1, wr, w0, bus.memRead, bus.memWrite, bus.memSource, ovf};
  endfunction

  // Called just after a falling edge with the instruction already on the bus.
  task automatic exec(input string tag);
    logic [57:0] exp;
    logic lng;
    exp = model();
    lng = (bus.opcode == 4'hF) &&
          ((bus.FN_offset == 4'd4) || ((bus.FN_offset == 4'd5) && (opnd_b() != 16'h0)));
    #1;
    if (lng) begin
      for (int c = 0; c <= 16; c++) begin
        chk($sformatf("%s_stall_c%0d", tag, c), 64'(bus.stall), 64'(c < 16));
        if (c > 0) chk($sformatf("%s_bubble_c%0d", tag, c), 64'(outv()), 64'h0);
        @(negedge clk); #1;
      end
    end else begin
      chk({tag, "_stall"}, 64'(bus.stall), 64'h0);
      @(negedge clk); #1;
    end
    chk({tag, "_result"}, 64'(outv()), 64'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    set_in(4'hF, 4'd4, 4'd1, 16'h0005, 16'h0007, 16'h0, 6'b110000);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(bus.stall), 64'h0);
    chk("rst_out", 64'(outv()), 64'h0);
    chk("rst_busy", 64'(bus.dbg_busy), 64'h0);
    set_in(4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b000000);
    reset = 1'b0;
    @(negedge clk); #1;

    set_in(4'hF, 4'd0, 4'd2, 16'h1234, 16'h0101, 16'h0, 6'b100000);  exec("add");
    set_in(4'hF, 4'd1, 4'd3, 16'h8000, 16'h0001, 16'h0, 6'b100000);  exec("sub_ovf");
    set_in(4'hF, 4'd0, 4'd4, 16'h7FFF, 16'h0000, 16'h0001, 6'b101000); exec("add_ovf_imm");
    set_in(4'hF, 4'd2, 4'd5, 16'hF0F0, 16'h0, 16'h3C3C, 6'b101000);  exec("and_imm");
    set_in(4'hF, 4'd3, 4'd6, 16'hF0F0, 16'h0F01, 16'h0, 6'b100001);  exec("or");
    set_in(4'hF, 4'd7, 4'd7, 16'h1111, 16'h2222, 16'h0, 6'b110000);  exec("bad_fn");
    set_in(4'hF, 4'd4, 4'd8, 16'hFFFE, 16'h0003, 16'h0, 6'b110000);  exec("mul");
    set_in(4'hF, 4'd5, 4'd9, 16'hFFF9, 16'h0002, 16'h0, 6'b110000);  exec("div_b2b");
    set_in(4'hF, 4'd5, 4'd10, 16'h8000, 16'hFFFF, 16'h0, 6'b110000); exec("div_ovf");
    set_in(4'hF, 4'd4, 4'd11, 16'h8000, 16'h8000, 16'h0, 6'b110000); exec("mul_minneg");
    set_in(4'hF, 4'd5, 4'd12, 16'h1234, 16'h0000, 16'h0, 6'b110000); exec("div0");
    set_in(4'h4, 4'd0, 4'd3, 16'hBEEF, 16'h0100, 16'hFFFC, 6'b000100); exec("load");

    reset = 1'b1;
    #1;
    chk("async_rst_out", 64'(outv()), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    set_in(4'hF, 4'd4, 4'd1, 16'h0123, 16'h0456, 16'h0, 6'b110000);
    #1;
    chk("rstb_stall0", 64'(bus.stall), 64'h1);
    repeat (8) @(negedge clk);
    #1;
    chk("rstb_count", 64'(bus.dbg_count), 64'd7);
    chk("rstb_busy", 64'(bus.dbg_busy), 64'h1);
    chk("rstb_stall7", 64'(bus.stall), 64'h1);
    reset = 1'b1;
    #1;
    chk("rstb_stall_cut", 64'(bus.stall), 64'h0);
    chk("rstb_out", 64'(outv()), 64'h0);
    chk("rstb_idle", 64'(bus.dbg_busy), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    set_in(4'hF, 4'd0, 4'd2, 16'h0010, 16'h0020, 16'h0, 6'b100000);  exec("add_after_rst");

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op, fn;
      logic [15:0] rd2;
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      fn  = 4'($urandom_range(0, 7));
      rd2 = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      set_in(op, fn, 4'($urandom_range(0, 15)), 16'($urandom), rd2,
             ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 6'($urandom_range(0, 63)));
      exec($sformatf("rand%0d", i));
    end

    set_in(4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b000000);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline, sitting directly after the ID/EX pipeline register and feeding the EX/MEM side. Each cycle it takes one decoded instruction: operands, sign-extended offset and control bits. It computes the ALU result or memory address and registers the result plus the pass-through control bits. Signed multiply and divide run iteratively over 16 cycles; while they run, the block asserts `stall` so the upstream stages hold.

## Interface
Parameters:
- `WIDTH`, 16, datapath width. Only 16 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  4  decoded opcode; 4'b1111 = R-type.
- `FN_offset`  in  4  R-type function code.
- `RA1`  in  4  destination / first source register number.
- `RA2`  in  4  second source register number.
- `RD1`, `RD2`  in  16 each  register operands.
- `SE_offset`  in  16  sign-extended immediate.
- `regWrite`, `r0Write`, `alusource`, `memRead`, `memWrite`, `memSource`  in  1 each  control bits from decode.
- `stall`  out  1  hold request to upstream stages (combinational).
- `ALUResult_o`  out  16  result, quotient, product low half, or memory address.
- `R0Result_o`  out  16  product high half or remainder, written to R0.
- `storeData_o`  out  16  registered `RD1`, used as store data.
- `destReg_o`  out  4  registered `RA1`.
- `regWrite_o`, `r0Write_o`, `memRead_o`, `memWrite_o`, `memSource_o`  out  1 each  registered control bits.
- `overflow_o`  out  1  arithmetic exception flag for the instruction in the output registers.

## Operation
- Operands: A = `RD1`; B = `alusource` ? `SE_offset` : `RD2`.
- R-type functions:
  - 0000 ADD, A+B.
  - 0001 SUB, A−B.
  - 0010 AND.
  - 0011 OR.
  - 0100 MUL: signed 16×16→32; low half to `ALUResult_o`, high half to `R0Result_o`.
  - 0101 DIV: signed; quotient truncates toward zero to `ALUResult_o`; remainder takes the dividend's sign and goes to `R0Result_o`.
  - Any other function code: result 0, `regWrite_o` forced 0.
- Non-R-type opcodes: `ALUResult_o` = `RD2` + `SE_offset`, mod 2^16, no overflow check.
- For single-cycle ops, `R0Result_o` = 0.
- ADD/SUB signed overflow sets `overflow_o`=1 and forces `regWrite_o`=0.
- DIV by zero sets `overflow_o`=1 and forces `regWrite_o`=`r0Write_o`=0. It completes in one cycle with no iteration.
- DIV 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0, `overflow_o`=1, with both writes suppressed. It still completes in 16 cycles.
- Control pass-through: `memRead`, `memWrite`, `memSource`, `regWrite` and `r0Write` are registered unchanged except where forced to 0 above.
- FSM has two states, IDLE and BUSY, plus a 4-bit step counter.
- IDLE:
  - A non-MUL/DIV op loads the output registers at the next edge.
  - A MUL/DIV op (other than DIV by zero) captures the operand magnitudes and result signs, clears the counter and moves to BUSY.
- BUSY:
  - Each edge performs one shift-add (MUL) or one restoring subtract (DIV) step and increments the counter.
  - Inputs are ignored.
  - On the edge with counter==15, the block loads the sign-corrected result into the output registers and returns to IDLE.
- `stall` = !reset & ((IDLE & MUL/DIV & !divzero) | (BUSY & counter!=15)).
- Bubble: on every edge where the output registers do not load a result, all control outputs, `overflow_o`, data outputs and `destReg_o` load 0.

## Timing
- Reset values: every output register is 0, state IDLE, counter 0, `stall` 0.
- Reset takes effect immediately and asynchronously. Reset during BUSY aborts the operation with no result emitted.
- Single-cycle op presented in cycle n: result is visible in cycle n+1.
- MUL/DIV presented in cycle 0:
  - `stall` is high in cycles 0–15 (16 cycles) and low in cycle 16.
  - The result is visible in cycle 17.
  - The upstream stage advances at the same edge that loads the result.
  - The output registers hold bubbles in cycles 1–16.
- Back-to-back MUL/DIV: the second one starts in the cycle its result becomes visible, with no extra gap.

## Test plan
- ADD: RD1=0x1234, RD2=0x0101, alusource=0, regWrite=1 → next cycle `ALUResult_o`=0x1335, `regWrite_o`=1, `overflow_o`=0, `stall` never high.
- SUB: RD1=0x8000, RD2=0x0001 → `ALUResult_o`=0x7FFF, `overflow_o`=1, `regWrite_o`=0.
- MUL: RD1=0xFFFE, RD2=0x0003, r0Write=1 → `stall` high for exactly 16 cycles; in cycle 17 `ALUResult_o`=0xFFFA, `R0Result_o`=0xFFFF, `r0Write_o`=1; bubbles in cycles 1–16.
- DIV cases:
  - 0xFFF9 / 0x0002 → quotient 0xFFFD, remainder 0xFFFF after 17 cycles.
  - Divisor 0 → result next cycle, `stall` stays 0, `overflow_o`=1, both writes 0.
- Reset: assert `reset` while BUSY at counter 7 → all outputs and `stall` go to 0 immediately; after release an ADD completes in one cycle.
- Load: opcode non-R-type, RD2=0x0100, SE_offset=0xFFFC, memRead=1 → `ALUResult_o`=0x00FC, `memRead_o`=1, `storeData_o`=RD1.
